core_lsu: RTL and testbench
===========================

CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; port list, clock and reset first:
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_read_i  in  1  load request from the EX/MEM register.
REQ-005 mem_write_i  in  1  store request from the EX/MEM register.
REQ-006 read_type_i  in  3  load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
REQ-007 write_type_i  in  2  store size: 00 SB, 01 SH, 10 SW, 11 SD.
REQ-008 addr_i  in  `OPERAND_WIDTH  byte address (ALU result).
REQ-009 wdata_i  in  `OPERAND_WIDTH  store data (rs2_data).
REQ-010 rdata_o  out  `OPERAND_WIDTH  extended load result, for mem2reg selection.
REQ-011 stall_o  out  1  hold IF through EX/MEM while a transaction is in flight.
REQ-012 misalign_o  out  1  current access is misaligned.
REQ-013 dmem_req_o / dmem_we_o  out  1 / 1  bus request / write enable.
REQ-014 dmem_addr_o  out  `OPERAND_WIDTH  doubleword-aligned address (addr_i with [2:0] forced to 0).
REQ-015 dmem_wdata_o / dmem_be_o  out  `OPERAND_WIDTH / 8  lane-shifted store data / byte enables.
REQ-016 dmem_gnt_i / dmem_rvalid_i  in  1 / 1  request accepted / read data valid.
REQ-017 dmem_rdata_i  in  `OPERAND_WIDTH  read doubleword.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ (waiting for gnt), RESP (waiting for rvalid), DONE (single cycle).
REQ-019 An op exists when mem_read_i or mem_write_i is set; if both are set, the read SHALL take priority and the write SHALL be ignored.
REQ-020 Alignment: H requires addr[0]=0, W requires addr[1:0]=0, D requires addr[2:0]=0; B is always aligned.
REQ-021 IDLE with an aligned op:
- dmem_req_o=1 combinationally and stall_o=1 in the same cycle.
- On gnt: read goes to RESP, write goes to DONE.
- Without gnt: go to REQ.
REQ-022 REQ:
- dmem_req_o=1 and stall_o=1.
- addr, we, be and wdata SHALL stay stable until gnt.
- On gnt: read goes to RESP, write goes to DONE.
REQ-023 RESP:
- dmem_req_o=0 and stall_o=1.
- On rvalid, register the extracted result into rdata_o and go to DONE.
REQ-024 DONE:
- stall_o=0 and dmem_req_o=0; always return to IDLE.
- The op still present in this cycle SHALL NOT be reissued.
REQ-025 Misaligned op in IDLE:
- misalign_o=1 combinationally.
- No bus request, stall_o=0, rdata_o unchanged.
REQ-026 Byte enables SHALL be {B:1, H:2, W:4, D:8} contiguous bits shifted left by addr[2:0].
REQ-027 dmem_wdata_o SHALL be wdata_i shifted left by 8*addr[2:0].
REQ-028 Load extraction:
- Right-shift dmem_rdata_i by 8*addr[2:0] and take the low 8/16/32/64 bits.
- Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU.
- read_type 111 SHALL be treated as LD.
REQ-029 The offset and type used for extraction SHALL be latched at request acceptance, not sampled at rvalid.
REQ-030 dmem_rvalid_i outside RESP SHALL be ignored.
REQ-031 Minimum latency: a store stalls 1 cycle; a load stalls 2 cycles with gnt in cycle 0 and rvalid in cycle 1.
REQ-032 rdata_o SHALL hold its value until the next load completes.

Reset
REQ-033 While rst is high at a clock edge:
- State goes to IDLE and rdata_o is cleared to 0.
- The offset/type latches are cleared.
REQ-034 During and after reset, with no op present, dmem_req_o, dmem_we_o and stall_o SHALL read 0.
REQ-035 A reset asserted in REQ or RESP SHALL abandon the transaction; any late gnt or rvalid after reset SHALL be ignored.

Structure
REQ-036 read/write type encodings and FSM state codes SHALL live in defines.v beside `OPERAND_WIDTH.
REQ-037 The rdata_o register SHALL reuse the existing Reg sub-module, with wen driven by the RESP&rvalid condition.
REQ-038 Load extraction SHALL be a combinational sub-module core_lsu_ldext.

Verification
REQ-039 SD to addr 0x1000, wdata 0x1122334455667788, gnt in cycle 0 -> be=0xFF, we=1, dmem_addr=0x1000, stall high exactly 1 cycle.
REQ-040 SB to addr 0x1003, wdata 0xAB -> be=0x08, dmem_wdata[31:24]=0xAB, dmem_addr=0x1000.
REQ-041 LB vs LBU at addr 0x1005, rdata 0x0000_8000_0000_0000 with byte5=0x80 -> LB gives 0xFFFFFFFFFFFFFF80, LBU gives 0x80; LW at 0x1004 with upper word 0x80000000 -> 0xFFFFFFFF80000000.
REQ-042 LW at 0x1002 -> misalign_o=1, dmem_req_o never asserted, stall_o=0, rdata_o unchanged.
REQ-043 LD with gnt delayed 3 cycles and rvalid 2 cycles later -> addr/be stable through REQ, stall high 6 cycles, one DONE cycle.
REQ-044 rst pulsed in RESP, then a spurious rvalid -> FSM in IDLE, rdata_o=0, stall_o=0.

Source files
------------

// File: rtl/core_lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package core_lsu_pkg;

    localparam int unsigned OPERAND_WIDTH = 64;

    // Load funct3 encodings; 3'b111 is decoded as a full doubleword load.
    typedef enum logic [2:0] {
        READ_LB  = 3'b000,
        READ_LH  = 3'b001,
        READ_LW  = 3'b010,
        READ_LD  = 3'b011,
        READ_LBU = 3'b100,
        READ_LHU = 3'b101,
        READ_LWU = 3'b110,
        READ_LDX = 3'b111
    } read_type_e;

    // Store size encodings.
    typedef enum logic [1:0] {
        WRITE_SB = 2'b00,
        WRITE_SH = 2'b01,
        WRITE_SW = 2'b10,
        WRITE_SD = 2'b11
    } write_type_e;

    // Bus transaction states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // Unshifted byte-enable pattern for an access size (0:B 1:H 2:W 3:D).
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Natural alignment check of a byte offset against an access size.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return off[0] == 1'b0;
            2'b10:   return off[1:0] == 2'b00;
            default: return off == 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/Reg.sv
// Generic register with synchronous clear and write enable.
module Reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, clear on reset.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (wen)
            q <= d;
    end

endmodule

// File: rtl/core_lsu_ldext.sv
// Load data extraction: lane shift and sign/zero extension.
module core_lsu_ldext
    import core_lsu_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0] rdata,
    input  logic [2:0]               offset,
    input  logic [2:0]               read_type,
    output logic [OPERAND_WIDTH-1:0] result
);

    logic [OPERAND_WIDTH-1:0] shifted;

    // Move the addressed byte to lane 0, then extend per load type.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (read_type)
            READ_LB:  result = {{56{shifted[7]}},  shifted[7:0]};
            READ_LH:  result = {{48{shifted[15]}}, shifted[15:0]};
            READ_LW:  result = {{32{shifted[31]}}, shifted[31:0]};
            READ_LBU: result = {56'd0, shifted[7:0]};
            READ_LHU: result = {48'd0, shifted[15:0]};
            READ_LWU: result = {32'd0, shifted[31:0]};
            default:  result = shifted;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: single outstanding data-memory transaction with
// pipeline stall, alignment check, byte lanes and load extension.
module core_lsu
    import core_lsu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read_i,
    input  logic                     mem_write_i,
    input  logic [2:0]               read_type_i,
    input  logic [1:0]               write_type_i,
    input  logic [OPERAND_WIDTH-1:0] addr_i,
    input  logic [OPERAND_WIDTH-1:0] wdata_i,
    output logic [OPERAND_WIDTH-1:0] rdata_o,
    output logic                     stall_o,
    output logic                     misalign_o,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic [OPERAND_WIDTH-1:0] dmem_addr_o,
    output logic [OPERAND_WIDTH-1:0] dmem_wdata_o,
    output logic [7:0]               dmem_be_o,
    input  logic                     dmem_gnt_i,
    input  logic                     dmem_rvalid_i,
    input  logic [OPERAND_WIDTH-1:0] dmem_rdata_i
);

    lsu_state_e               state;
    logic [2:0]               off_q;
    logic [2:0]               type_q;
    logic                     op;
    logic                     is_write;
    logic [1:0]               size;
    logic [2:0]               off;
    logic                     aligned;
    logic                     start;
    logic                     accept;
    logic                     load_done;
    logic [OPERAND_WIDTH-1:0] ext_data;

    // Decode the request; a read wins when both strobes are set.
    always_comb begin
        op        = mem_read_i | mem_write_i;
        is_write  = mem_write_i & ~mem_read_i;
        size      = mem_read_i ? read_type_i[1:0] : write_type_i;
        off       = addr_i[2:0];
        aligned   = is_aligned(size, off);
        start     = (state == ST_IDLE) && op && aligned;
        accept    = dmem_req_o && dmem_gnt_i;
        load_done = (state == ST_RESP) && dmem_rvalid_i;
    end

    // Bus and pipeline outputs; address/lanes follow the held pipeline inputs.
    always_comb begin
        misalign_o   = (state == ST_IDLE) && op && !aligned;
        dmem_req_o   = start || (state == ST_REQ);
        stall_o      = dmem_req_o || (state == ST_RESP);
        dmem_we_o    = dmem_req_o && is_write;
        dmem_addr_o  = {addr_i[OPERAND_WIDTH-1:3], 3'b000};
        dmem_be_o    = size_mask(size) << off;
        dmem_wdata_o = wdata_i << {off, 3'b000};
    end

    // Transaction FSM plus capture of load offset/type at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            off_q  <= '0;
            type_q <= '0;
        end else begin
            if (accept && mem_read_i) begin
                off_q  <= off;
                type_q <= read_type_i;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (dmem_gnt_i)
                            state <= mem_read_i ? ST_RESP : ST_DONE;
                        else
                            state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt_i)
                        state <= mem_read_i ? ST_RESP : ST_DONE;
                end
                ST_RESP: begin
                    if (dmem_rvalid_i)
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    core_lsu_ldext u_ldext (
        .rdata     (dmem_rdata_i),
        .offset    (off_q),
        .read_type (type_q),
        .result    (ext_data)
    );

    Reg #(.WIDTH(OPERAND_WIDTH)) u_rdata_reg (
        .clk (clk),
        .rst (rst),
        .wen (load_done),
        .d   (ext_data),
        .q   (rdata_o)
    );

endmodule

// File: tb/tb_core_lsu.sv
// Directed self-checking bench for core_lsu.
module tb_core_lsu;
    import core_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  read_type_i;
    logic [1:0]  write_type_i;
    logic [63:0] addr_i, wdata_i;
    logic [63:0] rdata_o;
    logic        stall_o, misalign_o, dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;

    int n_checks = 0;
    int n_pass   = 0;

    int          o_stalls;
    bit          o_req_seen, o_mis, o_stable, o_done, o_we;
    logic [63:0] o_addr, o_wdata;
    logic [7:0]  o_be;

    core_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .read_type_i   (read_type_i),
        .write_type_i  (write_type_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    endtask

    // Run one op: grant arrives gnt_dly cycles after issue, rvalid rv_dly after grant.
    // With scramble set, addr/type are corrupted once the request is accepted.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] rt,
                         input logic [1:0] wt, input logic [63:0] a, input logic [63:0] wd,
                         input int gnt_dly, input int rv_dly, input logic [63:0] rdat,
                         input bit scramble);
        int cyc = 0;
        @(negedge clk);
        mem_read_i    = rd;
        mem_write_i   = wr;
        read_type_i   = rt;
        write_type_i  = wt;
        addr_i        = a;
        wdata_i       = wd;
        dmem_rdata_i  = rdat;
        dmem_gnt_i    = (gnt_dly == 0);
        dmem_rvalid_i = 1'b0;
        o_stalls = 0; o_req_seen = 0; o_stable = 1; o_done = 0; o_mis = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (k == 0) begin
                o_addr  = dmem_addr_o;
                o_be    = dmem_be_o;
                o_we    = dmem_we_o;
                o_wdata = dmem_wdata_o;
                o_mis   = misalign_o;
            end
            if (dmem_req_o) begin
                o_req_seen = 1;
                if (dmem_addr_o !== o_addr || dmem_be_o !== o_be ||
                    dmem_we_o !== o_we || dmem_wdata_o !== o_wdata)
                    o_stable = 0;
            end
            if (!stall_o) begin
                o_done = 1;
                break;
            end
            o_stalls++;
            @(negedge clk);
            cyc++;
            dmem_gnt_i    = (cyc == gnt_dly);
            dmem_rvalid_i = rd && (cyc == gnt_dly + rv_dly);
            if (scramble && cyc > gnt_dly) begin
                addr_i      = 64'h0;
                read_type_i = 3'b011;
            end
        end
        check("op_completes", {63'd0, o_done}, 64'd1);
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_read_i = 0; mem_write_i = 0; read_type_i = 0; write_type_i = 0;
        addr_i = 0; wdata_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   {63'd0, dmem_req_o}, 64'd0);
        check("rst_we",    {63'd0, dmem_we_o},  64'd0);
        check("rst_stall", {63'd0, stall_o},    64'd0);
        check("rst_rdata", rdata_o, 64'd0);
        rst = 1'b0;

        // LB, byte 5 = 0x80
        do_op(1, 0, 3'b000, 2'b00, 64'h1005, 64'h0, 0, 1, 64'h0000_8000_0000_0000, 0);
        check("lb_stalls", 64'(o_stalls), 64'd2);
        check("lb_be",     {56'd0, o_be}, 64'h20);
        check("lb_addr",   o_addr, 64'h1000);
        check("lb_we",     {63'd0, o_we}, 64'd0);
        check("lb_rdata",  rdata_o, 64'hFFFF_FFFF_FFFF_FF80);

        // LBU, same data
        do_op(1, 0, 3'b100, 2'b00, 64'h1005, 64'h0, 0, 1, 64'h0000_8000_0000_0000, 0);
        check("lbu_rdata", rdata_o, 64'h80);

        // LW upper word
        do_op(1, 0, 3'b010, 2'b00, 64'h1004, 64'h0, 0, 1, 64'h8000_0000_0000_0000, 0);
        check("lw_be",    {56'd0, o_be}, 64'hF0);
        check("lw_rdata", rdata_o, 64'hFFFF_FFFF_8000_0000);

        // LHU with addr/type corrupted after grant: latched values must be used
        do_op(1, 0, 3'b101, 2'b00, 64'h1002, 64'h0, 0, 1, 64'h0000_0000_F00D_0000, 1);
        check("lhu_be",    {56'd0, o_be}, 64'h0C);
        check("lhu_rdata", rdata_o, 64'h0000_0000_0000_F00D);

        // Misaligned LW
        do_op(1, 0, 3'b010, 2'b00, 64'h1002, 64'h0, 0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0);
        check("mis_flag",   {63'd0, o_mis}, 64'd1);
        check("mis_req",    {63'd0, o_req_seen}, 64'd0);
        check("mis_stalls", 64'(o_stalls), 64'd0);
        check("mis_rdata",  rdata_o, 64'h0000_0000_0000_F00D);

        // LD with grant delayed 3 cycles, rvalid 2 cycles after grant
        do_op(1, 0, 3'b011, 2'b00, 64'h1008, 64'h0, 3, 2, 64'h0123_4567_89AB_CDEF, 0);
        check("ld_stalls", 64'(o_stalls), 64'd6);
        check("ld_stable", {63'd0, o_stable}, 64'd1);
        check("ld_be",     {56'd0, o_be}, 64'hFF);
        check("ld_addr",   o_addr, 64'h1008);
        check("ld_rdata",  rdata_o, 64'h0123_4567_89AB_CDEF);

        // read_type 111 acts as LD
        do_op(1, 0, 3'b111, 2'b00, 64'h1010, 64'h0, 0, 1, 64'hFEDC_BA98_7654_3210, 0);
        check("ldx_rdata", rdata_o, 64'hFEDC_BA98_7654_3210);

        // Read and write both set: read wins
        do_op(1, 1, 3'b010, 2'b11, 64'h1000, 64'h55, 0, 1, 64'h0000_0000_7FFF_FFFF, 0);
        check("prio_we",    {63'd0, o_we}, 64'd0);
        check("prio_rdata", rdata_o, 64'h0000_0000_7FFF_FFFF);

        // SD
        do_op(0, 1, 3'b000, 2'b11, 64'h1000, 64'h1122_3344_5566_7788, 0, 1, 64'h0, 0);
        check("sd_stalls", 64'(o_stalls), 64'd1);
        check("sd_be",     {56'd0, o_be}, 64'hFF);
        check("sd_we",     {63'd0, o_we}, 64'd1);
        check("sd_addr",   o_addr, 64'h1000);
        check("sd_wdata",  o_wdata, 64'h1122_3344_5566_7788);
        check("sd_rdata_hold", rdata_o, 64'h0000_0000_7FFF_FFFF);

        // SB to byte 3
        do_op(0, 1, 3'b000, 2'b00, 64'h1003, 64'hAB, 0, 1, 64'h0, 0);
        check("sb_be",     {56'd0, o_be}, 64'h08);
        check("sb_wdata",  o_wdata, 64'h0000_0000_AB00_0000);
        check("sb_addr",   o_addr, 64'h1000);
        check("sb_stalls", 64'(o_stalls), 64'd1);

        // Misaligned SH
        do_op(0, 1, 3'b000, 2'b01, 64'h1001, 64'h1234, 0, 1, 64'h0, 0);
        check("sh_mis_flag", {63'd0, o_mis}, 64'd1);
        check("sh_mis_req",  {63'd0, o_req_seen}, 64'd0);

        // rvalid in IDLE is ignored
        @(negedge clk);
        dmem_rdata_i  = 64'h5555_5555_5555_5555;
        dmem_rvalid_i = 1'b1;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        #1;
        check("idle_rvalid", rdata_o, 64'h0000_0000_7FFF_FFFF);

        // Reset while waiting for rvalid, then late rvalid/gnt
        @(negedge clk);
        mem_read_i  = 1'b1;
        read_type_i = 3'b011;
        addr_i      = 64'h2000;
        dmem_gnt_i  = 1'b1;
        @(negedge clk);
        mem_read_i = 1'b0;
        dmem_gnt_i = 1'b0;
        #1;
        check("resp_stall", {63'd0, stall_o}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        dmem_rdata_i  = 64'hDEAD_DEAD_DEAD_DEAD;
        dmem_rvalid_i = 1'b1;
        dmem_gnt_i    = 1'b1;
        #1;
        check("rst_resp_req", {63'd0, dmem_req_o}, 64'd0);
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i    = 1'b0;
        #1;
        check("rst_resp_stall", {63'd0, stall_o}, 64'd0);
        check("rst_resp_rdata", rdata_o, 64'd0);
        check("rst_resp_req2",  {63'd0, dmem_req_o}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
